cla_multiword_seq: RTL
======================

// Module: cla_multiword_seq
// PURPOSE
// - Multi-precision add/subtract sequencer. Runs WORDS*32-bit operations through one shared 32-bit carry-lookahead adder, one word per cycle.
// - Chains the carry between words through a register. Uses a valid/ready handshake on both the input side and the result side.
// - Sits between wide-arithmetic clients and the single 32-bit adder instance.
// PARAMETERS
// - WORDS  4  number of 32-bit words per operand; legal range >= 1; operand width W = 32*WORDS
// PORTS
// - i_clk    in   1   single clock; all state changes on its rising edge
// - i_rst    in   1   reset, synchronous, active-high
// - i_valid  in   1   request valid; i_sub, i_a and i_b are sampled when i_valid & o_ready
// - o_ready  out  1   block idle and able to accept a request
// - i_sub    in   1   0: compute A+B; 1: compute A-B (adder sees ~B with carry-in 1)
// - i_a      in   W   operand A
// - i_b      in   W   operand B
// - o_valid  out  1   result valid; held until i_ready
// - i_ready  in   1   consumer accepts the result
// - o_s      out  W   result register
// - o_c      out  1   final carry-out; for subtract, 1 = no borrow
// - o_ovf    out  1   signed two's-complement overflow of the W-bit result
// BEHAVIOUR
// - FSM states: IDLE, RUN, DONE. Reset state is IDLE.
// - Reset values: o_ready=1, o_valid=0, o_s=0, o_c=0, o_ovf=0; word index=0; carry reg=0.
// - Reset has priority over every other event. Reset asserted mid-RUN or in DONE aborts the operation; the next cycle is IDLE with all reset values.
// - IDLE: o_ready=1. On i_valid=1, latch A, B and i_sub (B stored as ~B if i_sub=1); carry reg <= i_sub; idx <= 0; go to RUN.
// - RUN: o_ready=0. Adder inputs are A[idx], B'[idx] and carry reg. Each edge writes o_s[idx] <= sum and carry reg <= adder carry-out, then idx <= idx+1.
// - RUN exit: on the edge where idx=WORDS-1:
//   - o_c <= adder carry-out.
//   - o_ovf <= cin_msb ^ cout, where cin_msb = A[W-1] ^ B'[W-1] ^ sum[31] of the top word.
//   - Go to DONE.
// - Latency: o_valid rises exactly WORDS cycles after the accept edge. With WORDS=1 the block goes IDLE -> RUN (1 cycle) -> DONE.
// - DONE: o_valid=1. o_s, o_c and o_ovf are held stable. i_valid is ignored (o_ready=0). On i_ready=1, go to IDLE next cycle (o_valid=0, o_ready=1).
// - No accept in the same cycle as a result handoff. Minimum request spacing is WORDS+2 cycles.
// - o_s contents are defined only while o_valid=1; partial words are visible during RUN.
// - The counter is ceil(log2(WORDS)) bits wide, minimum 1. It never wraps past WORDS-1 and is cleared on accept.
// - i_valid in RUN is ignored. Requesters must hold i_valid until accepted.
// - i_ready outside DONE has no effect.
// - All arithmetic is modulo 2^W. No inputs are sign-extended.
// TESTING (WORDS=4 unless stated)
// - Reset: i_rst=1 for 2 cycles -> o_ready=1, o_valid=0, o_s=0, o_c=0, o_ovf=0.
// - Full carry ripple: A=128'hFFFF..FF, B=1, add -> o_s=0, o_c=1, o_ovf=0; o_valid exactly 4 cycles after accept.
// - Cross-word carry: A=128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1 -> o_s=128'h0000_0000_0000_0001_0000_0000_0000_0000, o_c=0.
// - Subtract and overflow: 5-7 -> o_s=128'hFFFF..FFFE, o_c=0, o_ovf=0; 128'h7FFF..FF + 1 -> o_s=128'h8000..00, o_ovf=1.
// - Backpressure: hold i_ready=0 for 10 cycles in DONE, pulsing i_valid -> o_s, o_c and o_ovf are stable and no new accept occurs; then i_ready=1 -> o_ready=1 next cycle.
// - Reset mid-RUN at idx=2 -> next cycle IDLE with reset values; a following 3+4 returns o_s=7. Repeat the add tests with WORDS=1 (latency 1).

Source files
------------

// File: rtl/cla_multiword_seq.sv
// Multi-precision add/subtract sequencer: a WORDS*32-bit operation is pushed through
// one shared 32-bit carry-lookahead adder, least-significant word first, one word per cycle.
module cla_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_sub,
  input  logic [32*WORDS-1:0]   i_a,
  input  logic [32*WORDS-1:0]   i_b,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [32*WORDS-1:0]   o_s,
  output logic                  o_c,
  output logic                  o_ovf
);

  localparam int W     = 32 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // 32-bit adder built from eight 4-bit groups; group carries come from group generate/propagate.
  function automatic logic [32:0] cla32(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 8; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k]   | (p[4*k]   & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])   | (p[4*k+1] & p[4*k]   & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    return {gc[8], p ^ c};
  endfunction

  logic [1:0]       state_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;

  int               word_base_s;
  logic [31:0]      a_word_s;
  logic [31:0]      b_word_s;
  logic [32:0]      add_out_s;
  logic [31:0]      sum_s;
  logic             cout_s;
  logic             ovf_s;

  // Select the current word and run it through the shared adder.
  always_comb begin
    word_base_s = 32 * int'(idx_r);
    a_word_s    = a_r[word_base_s +: 32];
    b_word_s    = b_r[word_base_s +: 32];
    add_out_s   = cla32(a_word_s, b_word_s, carry_r);
    sum_s       = add_out_s[31:0];
    cout_s      = add_out_s[32];
    // Carry into the sign bit versus carry out of it flags signed overflow.
    ovf_s       = (a_word_s[31] ^ b_word_s[31] ^ sum_s[31]) ^ cout_s;
  end

  // Sequencer: accept, one word per cycle, hold the result until consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      carry_r <= 1'b0;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_s     <= {W{1'b0}};
      o_c     <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            a_r     <= i_a;
            b_r     <= i_sub ? ~i_b : i_b;
            carry_r <= i_sub;
            idx_r   <= {IDX_W{1'b0}};
            o_ready <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          o_s[word_base_s +: 32] <= sum_s;
          carry_r                <= cout_s;
          if (idx_r == IDX_LAST) begin
            o_c     <= cout_s;
            o_ovf   <= ovf_s;
            o_valid <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
